// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, aligned 32-bit bus, one-cycle issue,
// response the cycle after issue; misaligned or illegal-size requests fault without touching the bus.
module mem_lsu (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic        enable_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] addr_o,
  output logic [31:0] wvalue_o,
  input  logic [31:0] rvalue_i
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_e;

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wvalue_q, wvalue_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;

  logic        accept, misalign;
  logic [3:0]  strb_base;
  logic [NUM_LANES-1:0][7:0] wv_rep;
  logic [31:0] rsh;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign misalign    = (req_size_i == 2'd3) ||
                       ((req_size_i == 2'd1) && req_addr_i[0]) ||
                       ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'd0));

  always_comb begin
    case (req_size_i)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // Each bus lane picks the store byte that lands on it for the given size.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      case (req_size_i)
        2'd0:    wv_rep[i] = req_wdata_i[7:0];
        2'd1:    wv_rep[i] = req_wdata_i[8*(i%2) +: 8];
        default: wv_rep[i] = req_wdata_i[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    wstrb_d  = 4'b0;
    addr_d   = 32'b0;
    wvalue_d = 32'b0;
    we_d     = we_q;
    size_d   = size_q;
    off_d    = off_q;
    uns_d    = uns_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = req_we_i;
          size_d = req_size_i;
          off_d  = req_addr_i[1:0];
          uns_d  = req_unsigned_i;
          if (misalign) begin
            state_d = FAULT;
          end else begin
            state_d  = ISSUE;
            enable_d = 1'b1;
            addr_d   = {req_addr_i[31:2], 2'b00};
            wstrb_d  = req_we_i ? (strb_base << req_addr_i[1:0]) : 4'b0;
            wvalue_d = wv_rep;
          end
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      wstrb_q  <= 4'b0;
      addr_q   <= 32'b0;
      wvalue_q <= 32'b0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      off_q    <= 2'd0;
      uns_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wvalue_q <= wvalue_d;
      we_q     <= we_d;
      size_q   <= size_d;
      off_q    <= off_d;
      uns_q    <= uns_d;
    end
  end

  assign enable_o = enable_q;
  assign wstrb_o  = wstrb_q;
  assign addr_o   = addr_q;
  assign wvalue_o = wvalue_q;

  // Aligned words always have offset 0, so the shifted value serves all sizes.
  assign rsh = rvalue_i >> {off_q, 3'b000};

  always_comb begin
    resp_valid_o = (state_q == WAIT) || (state_q == FAULT);
    resp_fault_o = (state_q == FAULT);
    resp_rdata_o = 32'b0;
    if ((state_q == WAIT) && !we_q) begin
      case (size_q)
        2'd0:    resp_rdata_o = {{24{rsh[7]  & ~uns_q}}, rsh[7:0]};
        2'd1:    resp_rdata_o = {{16{rsh[15] & ~uns_q}}, rsh[15:0]};
        default: resp_rdata_o = rsh;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, random requests against an
// arithmetic reference model, back-to-back acceptance and reset abort.
module tb_mem_lsu;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_fault_o, enable_o;
  logic [31:0] resp_rdata_o, addr_o, wvalue_o, rvalue_i;
  logic [3:0]  wstrb_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_fault_o(resp_fault_o),
    .enable_o(enable_o), .wstrb_o(wstrb_o), .addr_o(addr_o), .wvalue_o(wvalue_o),
    .rvalue_i(rvalue_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rv;
    logic        fault;
    logic [31:0] baddr;
    logic [3:0]  wstrb;
    logic [31:0] wvalue;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the access rules, using plain arithmetic.
  function automatic vec_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rv);
    vec_t v;
    int unsigned off, b;
    off = addr % 4;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rv = rv;
    v.fault  = (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && off != 0);
    v.baddr  = addr - off;
    v.wstrb  = !we ? 4'd0 : (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'd15;
    v.wvalue = (size == 0) ? (wdata % 256) * 32'h01010101 :
               (size == 1) ? (wdata % 65536) * 32'h00010001 : wdata;
    if (we) v.rdata = 0;
    else if (size == 0) begin
      b = (rv >> (8 * off)) % 256;
      v.rdata = (!uns && b >= 128) ? (b + 32'hFFFFFF00) : b;
    end else if (size == 1) begin
      b = (rv >> (8 * off)) % 65536;
      v.rdata = (!uns && b >= 32768) ? (b + 32'hFFFF0000) : b;
    end else v.rdata = rv;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk_i);
    chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    if (v.fault) begin
      chk({tag, " fault_valid"}, 32'(resp_valid_o), 32'd1);
      chk({tag, " fault_flag"},  32'(resp_fault_o), 32'd1);
      chk({tag, " fault_rdata"}, resp_rdata_o, 32'd0);
      chk({tag, " fault_en"},    32'(enable_o), 32'd0);
      @(negedge clk_i);
      chk({tag, " fault_end"}, {31'd0, resp_valid_o} | {30'd0, enable_o, 1'b0}, 32'd0);
    end else begin
      chk({tag, " en"},    32'(enable_o), 32'd1);
      chk({tag, " addr"},  addr_o, v.baddr);
      chk({tag, " wstrb"}, 32'(wstrb_o), 32'(v.wstrb));
      if (v.we) chk({tag, " wvalue"}, wvalue_o, v.wvalue);
      chk({tag, " early_resp"}, 32'(resp_valid_o), 32'd0);
      @(posedge clk_i); #1 rvalue_i = v.rv;
      @(negedge clk_i);
      chk({tag, " resp_valid"}, 32'(resp_valid_o), 32'd1);
      chk({tag, " resp_fault"}, 32'(resp_fault_o), 32'd0);
      chk({tag, " rdata"},      resp_rdata_o, v.rdata);
      chk({tag, " en_off"},     32'(enable_o), 32'd0);
      @(posedge clk_i); #1 rvalue_i = 32'd0;
    end
    chk({tag, " ready_back"}, 32'(req_ready_o), 32'd1);
  endtask

  vec_t tbl[11];
  int acc[2];
  int n, low_cnt;

  initial begin
    rstn_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0; rvalue_i = 32'd0;
    #1 rstn_i = 1'b0;
    #2;
    chk("rst ready", 32'(req_ready_o), 32'd1);
    chk("rst bus", {31'd0, enable_o} | 32'(wstrb_o) | addr_o | wvalue_o, 32'd0);
    chk("rst resp", {31'd0, resp_valid_o} | {31'd0, resp_fault_o} | resp_rdata_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i); rstn_i = 1'b1;

    //       we    size  uns   addr          wdata         rv            flt   baddr         wstrb    wvalue        rdata
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h00001003, 32'h000000A5, 32'h12345678, 1'b0, 32'h00001000, 4'b1000, 32'hA5A5A5A5, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h00002002, 32'h0,        32'h0080FF00, 1'b0, 32'h00002000, 4'b0000, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h00002002, 32'h0,        32'h80011234, 1'b0, 32'h00002000, 4'b0000, 32'h0,        32'h00008001};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h00002002, 32'h0,        32'h80011234, 1'b0, 32'h00002000, 4'b0000, 32'h0,        32'hFFFF8001};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h00002001, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h00001002, 32'hBEEFCAFE, 32'h0,        1'b0, 32'h00001000, 4'b1100, 32'hCAFECAFE, 32'h0};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h00000004, 32'h11223344, 32'h0,        1'b0, 32'h00000004, 4'b1111, 32'h11223344, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h00000008, 32'h0,        32'hDEADBEEF, 1'b0, 32'h00000008, 4'b0000, 32'h0,        32'hDEADBEEF};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h00000001, 32'h5555AAAA, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h00000003, 32'h0,        32'h80000000, 1'b0, 32'h00000000, 4'b0000, 32'h0,        32'h00000080};
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (a[1:0] & 2'b10);
      run_vec(model(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom),
              $sformatf("rnd%0d", i));
    end

    // Back-to-back word stores with req_valid_i held high.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h100; req_wdata_i = 32'hAAAA0001;
    n = 0; low_cnt = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      if (k != 0) @(negedge clk_i);
      if (req_ready_o) begin
        acc[n] = cyc; n++;
        @(posedge clk_i); #1;
        if (n == 1) begin req_addr_i = 32'h200; req_wdata_i = 32'hBBBB0002; end
        else req_valid_i = 1'b0;
      end else if (n == 1) low_cnt++;
    end
    chk("b2b accepted", 32'(n), 32'd2);
    if (n == 2) chk("b2b spacing", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b ready_low", 32'(low_cnt), 32'd2);
    @(negedge clk_i);
    chk("b2b 2nd addr", addr_o, 32'h200);
    chk("b2b 2nd wvalue", wvalue_o, 32'hBBBB0002);
    repeat (2) @(negedge clk_i);

    // Reset pulse while the access is in ISSUE.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h300;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("abort en_before", 32'(enable_o), 32'd1);
    rstn_i = 1'b0; #1;
    chk("abort en_async", 32'(enable_o), 32'd0);
    chk("abort addr", addr_o, 32'd0);
    chk("abort ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i); rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("abort no_resp%0d", k), {31'd0, resp_valid_o} | {30'd0, enable_o, 1'b0}, 32'd0);
    end
    chk("abort ready_after", 32'(req_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: none; the bus is fixed at 32-bit address, 32-bit data and 4 byte strobes.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rstn_i  input  1  reset; asynchronous, active-low.
REQ-004 req_valid_i  input  1  CPU presents a load/store request.
REQ-005 req_ready_o  output  1  LSU can accept a request; high only in IDLE.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_size_i  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 req_unsigned_i  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-009 req_addr_i  input  32  byte address.
REQ-010 req_wdata_i  input  32  store data, right-aligned.
REQ-011 resp_valid_o  output  1  one-cycle response pulse.
REQ-012 resp_rdata_o  output  32  extended load data; 0 for stores and faults.
REQ-013 resp_fault_o  output  1  misaligned or illegal-size request; qualified by resp_valid_o.
REQ-014 enable_o  output  1  bus access strobe.
REQ-015 wstrb_o  output  4  byte write strobes; 0 means read.
REQ-016 addr_o  output  32  word-aligned bus address.
REQ-017 wvalue_o  output  32  lane-replicated store data.
REQ-018 rvalue_i  input  32  bus read data; valid the cycle after enable_o; 0 otherwise.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and FAULT.
REQ-020 A request is accepted when req_valid_i and req_ready_o are both high; inputs are sampled only in that cycle.
REQ-021 An accepted request SHALL go to FAULT when any of the following holds: size 3; size 1 with addr[0] = 1; size 2 with addr[1:0] != 0. Otherwise it SHALL go to ISSUE.
REQ-022 The bus outputs (enable_o, wstrb_o, addr_o, wvalue_o) SHALL be registered and hold their issue values only during ISSUE, which lasts exactly one cycle; they SHALL be 0 in every other state.
REQ-023 In ISSUE:
- addr_o = {addr[31:2], 2'b00}.
- Load: wstrb_o = 0.
- Store byte: wstrb_o = 4'b0001 << addr[1:0].
- Store half: wstrb_o = 4'b0011 << addr[1:0].
- Store word: wstrb_o = 4'b1111.
REQ-024 wvalue_o SHALL be:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata
REQ-025 ISSUE SHALL always go to WAIT. In WAIT, resp_valid_o = 1 and resp_fault_o = 0.
REQ-026 In WAIT, resp_rdata_o SHALL be computed combinationally from rvalue_i, using the offset, size and unsigned flag captured at accept:
- byte: rvalue_i >> (8 * offset), lane [7:0], extended.
- half: rvalue_i >> (8 * offset), lane [15:0], extended.
- word: rvalue_i unchanged.
REQ-027 A store response in WAIT SHALL drive resp_rdata_o = 0.
REQ-028 WAIT SHALL always go to IDLE.
REQ-029 In FAULT, for exactly one cycle: resp_valid_o = 1, resp_fault_o = 1, resp_rdata_o = 0, no bus access. FAULT SHALL then go to IDLE.
REQ-030 Latency:
- Normal request: accept in cycle N, enable_o in N+1, response in N+2, req_ready_o high again in N+3.
- Faulting request: response in N+1.
REQ-031 Outside WAIT and FAULT, resp_valid_o, resp_fault_o and resp_rdata_o SHALL be 0.
REQ-032 When req_ready_o is low, req_valid_i SHALL be ignored and no request state SHALL change.

Reset
REQ-033 While rstn_i is low, with no clock required:
- state = IDLE; req_ready_o = 1.
- enable_o, wstrb_o, addr_o, wvalue_o = 0.
- resp_valid_o, resp_fault_o, resp_rdata_o = 0.
REQ-034 Reset asserted in ISSUE or WAIT SHALL abort the access immediately; after release, no response is produced for the aborted request.

Verification
REQ-035 Store byte: addr 0x1003, wdata 0x000000A5 -> next cycle enable_o = 1, addr_o = 0x1000, wstrb_o = 4'b1000, wvalue_o = 0xA5A5A5A5; the cycle after, resp_valid_o = 1 with rdata 0.
REQ-036 Signed byte load: addr 0x2002, size 0, rvalue_i = 0x0080FF00 in WAIT -> resp_rdata_o = 0xFFFFFF80.
REQ-037 Half loads: addr 0x2002, size 1, rvalue_i = 0x8001xxxx:
- unsigned -> 0x00008001
- signed -> 0xFFFF8001
REQ-038 Faults: word load at 0x2001, and size 3 at 0x0 -> resp_valid_o = 1 and resp_fault_o = 1 one cycle after accept; enable_o never asserted.
REQ-039 Back-to-back: req_valid_i held high with two word stores -> second accepted exactly 3 cycles after the first; req_ready_o low in between.
REQ-040 Reset mid-op: rstn_i pulsed low during ISSUE -> enable_o drops to 0 asynchronously, no resp_valid_o, req_ready_o = 1 after release.
